// File: rtl/rr_req_gnt_arbiter.sv
// rr_req_gnt_arbiter: N-way round-robin arbiter with a registered one-hot grant and a registered grant index.
// Define ARB_HOLD_LIMIT_EN to force rotation after MAX_HOLD cycles when others wait; this also enables the preempt pulse.
module rr_req_gnt_arbiter #(
   parameter  int N_REQ    = 4,
   parameter  int MAX_HOLD = 8,
   localparam int IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             gnt_valid,
   output logic [IDW-1:0]   gnt_id,
   output logic             preempt
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

   state_e             state_q, state_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic               gnt_valid_q;
   logic [IDW-1:0]     gnt_id_q, gnt_id_d;
   logic               others_s;
   logic [IDW-1:0]     after_owner_s;
`ifdef ARB_HOLD_LIMIT_EN
   localparam int HCW = $clog2(MAX_HOLD + 1);
   logic [HCW-1:0]     hold_q, hold_d;
   logic               preempt_q, preempt_d;
`endif

   function automatic logic [IDW-1:0] inc_id(input logic [IDW-1:0] id);
      if (int'(id) >= N_REQ - 1) begin
         return '0;
      end else begin
         return IDW'(int'(id) + 1);
      end
   endfunction

   // First requester at or after p, wrapping; scanned downwards so the nearest one wins.
   function automatic logic [IDW-1:0] pick(input logic [N_REQ-1:0] r, input logic [IDW-1:0] p);
      int             idx;
      logic [IDW-1:0] res;
      res = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(p) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end else begin
            idx = idx;
         end
         if (r[idx]) begin
            res = IDW'(idx);
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] id);
      logic [N_REQ-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      gnt_d         = gnt_q;
      gnt_id_d      = gnt_id_q;
      others_s      = |(req & ~gnt_q);
      after_owner_s = inc_id(gnt_id_q);
`ifdef ARB_HOLD_LIMIT_EN
      hold_d        = hold_q;
      preempt_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (|req) begin
               gnt_id_d = pick(req, ptr_q);
               gnt_d    = onehot(gnt_id_d);
               state_d  = GRANT;
`ifdef ARB_HOLD_LIMIT_EN
               hold_d   = HCW'(1);
`endif
            end else begin
               gnt_d    = '0;
            end
         end
         GRANT: begin
            if (!req[gnt_id_q]) begin
               ptr_d = after_owner_s;
               if (|req) begin
                  gnt_id_d = pick(req, after_owner_s);
                  gnt_d    = onehot(gnt_id_d);
`ifdef ARB_HOLD_LIMIT_EN
                  hold_d   = HCW'(1);
`endif
               end else begin
                  gnt_d    = '0;
                  state_d  = IDLE;
               end
            end
`ifdef ARB_HOLD_LIMIT_EN
            else if ((hold_q == HCW'(MAX_HOLD)) && others_s) begin
               ptr_d     = after_owner_s;
               gnt_id_d  = pick(req, after_owner_s);
               gnt_d     = onehot(gnt_id_d);
               hold_d    = HCW'(1);
               preempt_d = 1'b1;
            end
`endif
            else begin
`ifdef ARB_HOLD_LIMIT_EN
               // Saturate so a long sole owner never wraps back below the limit.
               if (hold_q != HCW'(MAX_HOLD)) begin
                  hold_d = hold_q + HCW'(1);
               end else begin
                  hold_d = hold_q;
               end
`else
               gnt_d = gnt_q;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
`ifdef ARB_HOLD_LIMIT_EN
         hold_q      <= '0;
         preempt_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= |gnt_d;
         gnt_id_q    <= gnt_id_d;
`ifdef ARB_HOLD_LIMIT_EN
         hold_q      <= hold_d;
         preempt_q   <= preempt_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_id    = gnt_id_q;
`ifdef ARB_HOLD_LIMIT_EN
   assign preempt   = preempt_q;
`else
   assign preempt   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Randomised plus directed bench for rr_req_gnt_arbiter, checked each cycle against a queue-free behavioural arbiter model.
module tb_rr_req_gnt_arbiter;
   localparam int N  = 4;
   localparam int MH = 8;
`ifdef ARB_HOLD_LIMIT_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req   = '0;
   logic [N-1:0] gnt;
   logic         gnt_valid;
   logic [1:0]   gnt_id;
   logic         preempt;

   rr_req_gnt_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .preempt(preempt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Behavioural model: who owns the bus, for how long, and where the rotation resumes.
   bit           m_busy;
   int           m_owner;
   int           m_ptr;
   int           m_hold;
   bit           m_pre;
   bit           prev_pre;
   logic [N-1:0] m_gnt;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++)
         if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_hold = 0; m_pre = 1'b0; prev_pre = 1'b0; m_gnt = '0;
   endtask

   task automatic model_step(input logic [N-1:0] r);
      logic [N-1:0] others;
      m_pre = 1'b0;
      if (!m_busy) begin
         if (r != '0) begin m_owner = pick(r, m_ptr); m_busy = 1'b1; m_hold = 1; end
      end else if (!r[m_owner]) begin
         m_ptr = (m_owner + 1) % N;
         if (r != '0) begin m_owner = pick(r, m_ptr); m_hold = 1; end
         else m_busy = 1'b0;
      end else begin
         others = r & ~(N'(1) << m_owner);
         if (HOLD_EN && m_hold == MH && others != '0) begin
            m_ptr = (m_owner + 1) % N; m_owner = pick(r, m_ptr); m_hold = 1; m_pre = 1'b1;
         end else if (m_hold < MH) m_hold++;
      end
      m_gnt = m_busy ? (N'(1) << m_owner) : '0;
   endtask

   task automatic compare();
      chk("gnt", int'(gnt), int'(m_gnt));
      chk("gnt_id", int'(gnt_id), m_owner);
      chk("gnt_valid", int'(gnt_valid), int'(m_busy));
      chk("preempt", int'(preempt), int'(m_pre));
      chk("preempt_back_to_back", int'(preempt & prev_pre), 0);
      prev_pre = preempt;
   endtask

   task automatic cycle(input logic [N-1:0] r);
      @(negedge clk);
      req = r;
      @(posedge clk);
      model_step(r);
      #1;
      compare();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      model_reset();
      #1;
      compare();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int           exp_id;
      int           exp_pre;
      logic [N-1:0] r;

      model_reset();
      do_reset();
      chk("reset_gnt", int'(gnt), 0);
      chk("reset_gnt_id", int'(gnt_id), 0);
      chk("reset_preempt", int'(preempt), 0);

      // Single request, one-cycle latency, then release.
      cycle(4'b0100);
      chk("single_gnt", int'(gnt), 4);
      chk("single_gnt_id", int'(gnt_id), 2);
      chk("single_valid", int'(gnt_valid), 1);
      cycle(4'b0000);
      chk("release_gnt", int'(gnt), 0);
      chk("release_valid", int'(gnt_valid), 0);
      chk("release_id_held", int'(gnt_id), 2);

      // All four requesting from reset.
      do_reset();
      for (int c = 0; c < 40; c++) begin
         cycle(4'b1111);
         exp_id  = HOLD_EN ? (c / MH) % N : 0;
         exp_pre = (HOLD_EN && c > 0 && (c % MH) == 0) ? 1 : 0;
         chk("rotate_id", int'(gnt_id), exp_id);
         chk("rotate_preempt", int'(preempt), exp_pre);
      end

      // Owner ch1 releases while ch3 waits: immediate handover.
      do_reset();
      cycle(4'b0010);
      cycle(4'b1010);
      cycle(4'b1000);
      chk("handover_gnt", int'(gnt), 8);
      chk("handover_preempt", int'(preempt), 0);

      // Sole requester keeps the grant.
      for (int c = 0; c < 20; c++) begin
         cycle(4'b1000);
         chk("sole_gnt", int'(gnt), 8);
         chk("sole_preempt", int'(preempt), 0);
      end

      // Two requesters held for 30 cycles, then ch0 drops.
      do_reset();
      for (int c = 0; c < 30; c++) begin
         cycle(4'b0011);
         exp_id = HOLD_EN ? (c / MH) % 2 : 0;
         chk("pair_id", int'(gnt_id), exp_id);
      end
      cycle(4'b0010);
      chk("pair_drop_gnt", int'(gnt), 2);

      // Asynchronous reset while ch2 owns.
      do_reset();
      cycle(4'b0100);
      cycle(4'b0100);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_gnt", int'(gnt), 0);
      compare();
      #2;
      req   = 4'b1100;
      rst_n = 1'b1;
      @(posedge clk);
      model_step(4'b1100);
      #1;
      compare();
      chk("after_reset_gnt", int'(gnt), 4);
      chk("after_reset_id", int'(gnt_id), 2);

      // Random traffic with sticky request patterns so long holds occur.
      do_reset();
      r = '0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
         cycle(r);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/rr_req_gnt_arbiter.md
Name: rr_req_gnt_arbiter

Overview:
Parametrised round-robin request/grant arbiter. It generalises the single-channel registered req->gnt responder to N_REQ requesters. Each requester gets a one-hot registered grant, held while its request stays high, with a bounded hold time so no requester starves. It sits between bus masters driving a clocking-block interface and a shared target; grants are launched on posedge clk.

Parameters:
N_REQ, 4, number of requesters (1..32)
MAX_HOLD, 8, max consecutive grant cycles before forced rotation when others are waiting (>=1)

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
req  input  N_REQ  per-channel request, level-sensitive, sampled on posedge clk
gnt  output  N_REQ  one-hot grant (all-zero when idle), registered
gnt_valid  output  1  OR of gnt, registered
gnt_id  output  IDW  index of granted channel; IDW = (N_REQ>1) ? $clog2(N_REQ) : 1
preempt  output  1  one-cycle pulse, registered, on a forced (hold-limit) handover

Behaviour:
- Reset (rst_n low, async, takes effect immediately):
  - gnt=0, gnt_valid=0, gnt_id=0, preempt=0.
  - Round-robin pointer ptr=0, hold_cnt=0, state=IDLE.
- Latency: request sampled at edge k produces a grant visible after edge k; one-cycle registered latency, as in the single-channel block.
- Selection function next(p): first set bit of req, searching p, p+1, ..., N_REQ-1, 0, ..., p-1.
- State IDLE, on each edge:
  - req==0: stay IDLE, outputs 0.
  - Otherwise grant o=next(ptr): gnt=1<<o, gnt_id=o, hold_cnt=1, go to GRANT.
- State GRANT (owner o), on each edge, evaluated in priority order:
  1. req[o]==0: ptr=(o+1) mod N_REQ.
     - Other requests pending: grant next(o+1) on the same edge, hold_cnt=1, no idle cycle.
     - Otherwise: gnt=0, go to IDLE.
  2. req[o]==1, hold_cnt==MAX_HOLD, another request pending: forced handover to next(o+1), ptr=(o+1) mod N_REQ, hold_cnt=1, preempt=1 for that cycle.
  3. Otherwise keep the grant; hold_cnt increments, saturating at MAX_HOLD.
- preempt is 0 in every cycle not covered by rule 2.
- gnt is always one-hot or zero.
- gnt_id holds its last value when gnt==0.
- gnt_valid==|gnt in every cycle.
- hold_cnt width is $clog2(MAX_HOLD+1); it never wraps.
- Simultaneous events:
  - Owner drop plus new requests on the same edge: handover per rule 1.
  - Requests arriving during a grant wait their turn; there is no priority preemption.
- N_REQ==1: gnt[0] follows req[0] with one-cycle latency; preempt is always 0.
- Reset mid-grant: grant drops asynchronously. After rst_n deasserts, arbitration restarts from ptr=0.

Optional Feature:
ARB_HOLD_LIMIT_EN
- Defined: hold-limit rule 2 is active as described; the preempt port pulses on forced handovers.
- Undefined: rule 2 is removed. The owner keeps the grant for as long as its req stays high; preempt is tied to 0; the hold_cnt logic is not generated. Port list is unchanged.

Test Plan:
- Reset with rst_n low, then release; req=4'b0100 sampled at edge k -> after edge k gnt=4'b0100, gnt_id=2, gnt_valid=1. req dropped at edge m -> after edge m gnt=0, gnt_valid=0.
- All four requests high from reset (hold limit enabled, MAX_HOLD=8):
  - ch0 granted 8 cycles, then ch1 with preempt=1 for one cycle, then ch2, then ch3, then back to ch0.
  - preempt never high two cycles in a row.
- Handover on release: ch1 owns, req=4'b1010, req[1] falls -> next cycle gnt=4'b1000, preempt=0, no gnt==0 cycle in between.
- Sole requester ch3 held high for 20 cycles -> gnt=4'b1000 for all 20 cycles, preempt stays 0, no rotation.
- Macro undefined, req=4'b0011 held for 30 cycles -> ch0 keeps grant all 30 cycles; ch1 granted on the cycle after req[0] falls.
- Async reset mid-grant: ch2 owns, rst_n pulsed low between edges -> gnt=0 immediately, before the next edge. After release with req=4'b1100 -> ch2 granted first (ptr reset to 0).
